// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB slave in front of a register file of N_REG registers, DW bits each.
// Per-register access type (RW / WO / RO) comes from RO_MASK and WO_MASK. Supports byte-strobed
// writes, separate read/write wait states, PSLVERR on illegal access and a one-cycle write pulse
// per register. Every output is driven straight from a flop.
// Optional feature: define APB_REGFILE_PPROT_EN to add input i_pprot and parameter PRIV_MASK.
// Registers flagged in PRIV_MASK then reject accesses made with pprot[0]=0.
module apb_regfile_slave #(
    parameter int unsigned      DW      = 32,
    parameter int unsigned      AW      = 8,
    parameter int unsigned      N_REG   = 8,
    parameter logic [N_REG-1:0] RO_MASK = 'h0,
    parameter logic [N_REG-1:0] WO_MASK = 'h0,
    parameter int unsigned      RD_WAIT = 1,
    parameter int unsigned      WR_WAIT = 0,
    parameter logic [DW-1:0]    RST_VAL = '0
`ifdef APB_REGFILE_PPROT_EN
    ,
    parameter logic [N_REG-1:0] PRIV_MASK = 'h0
`endif
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [AW-1:0]         i_paddr,
    input  logic                  i_pwrite,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic [DW-1:0]         i_pwdata,
    input  logic [DW/8-1:0]       i_pstrb,
`ifdef APB_REGFILE_PPROT_EN
    input  logic [2:0]            i_pprot,
`endif
    output logic [DW-1:0]         o_prdata,
    output logic                  o_pslverr,
    output logic                  o_pready,
    output logic [N_REG*DW-1:0]   o_hw_ctl,
    input  logic [N_REG*DW-1:0]   i_hw_sts,
    output logic [N_REG-1:0]      o_wr_pulse
);

    localparam int unsigned NB       = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(NB);
    localparam int unsigned IW       = AW - ADDR_LSB;

    // Elaboration-time parameter checks
    if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
        $error("DW must be 8, 16 or 32");
    end
    if (AW == 0 || AW > 32 || AW <= ADDR_LSB) begin : g_bad_aw
        $error("AW out of range");
    end
    if (N_REG == 0 || 64'(N_REG) > (64'd1 << IW)) begin : g_bad_nreg
        $error("N_REG must be in 1 .. 2**(AW-ADDR_LSB)");
    end
    if ((RO_MASK & WO_MASK) != '0) begin : g_bad_mask
        $error("A register cannot be both read-only and write-only");
    end
    if (RD_WAIT > 15 || WR_WAIT > 15) begin : g_bad_wait
        $error("RD_WAIT and WR_WAIT must be in 0..15");
    end

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [NB-1:0]    strb_q, strb_d;
    logic [N_REG-1:0] sel_q, sel_d;
    logic             err_q, err_d;
    logic             pready_q, pready_d;
    logic [DW-1:0]    prdata_q, prdata_d;
    logic             pslverr_q, pslverr_d;
    logic [N_REG-1:0] wr_pulse_q, wr_pulse_d;
    logic [DW-1:0]    reg_q [N_REG];
    logic [DW-1:0]    reg_d [N_REG];

    logic [IW-1:0]    setup_idx;
    logic [N_REG-1:0] setup_sel;
    logic             setup_priv_bad;
    logic             setup_err;

    logic             resp_write;
    logic             resp_err;
    logic [N_REG-1:0] resp_sel;
    logic [DW-1:0]    resp_rdata;

    assign setup_idx = i_paddr[AW-1:ADDR_LSB];

    // One-hot register select from the setup address; all-zero when unmapped
    always_comb begin
        setup_sel = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            setup_sel[i] = (33'(setup_idx) == 33'(i));
        end
    end

`ifdef APB_REGFILE_PPROT_EN
    assign setup_priv_bad = (|(setup_sel & PRIV_MASK)) & ~i_pprot[0];
`else
    assign setup_priv_bad = 1'b0;
`endif

    // The error verdict is fixed at setup so later pprot/paddr changes cannot alter it
    assign setup_err = ~(|setup_sel) | setup_priv_bad |
                       (i_pwrite ? (|(setup_sel & RO_MASK)) : (|(setup_sel & WO_MASK)));

    // Response source: live setup inputs while idle (zero-wait case), captured copy otherwise
    always_comb begin
        if (state_q == StIdle) begin
            resp_write = i_pwrite;
            resp_sel   = setup_sel;
            resp_err   = setup_err;
        end else begin
            resp_write = write_q;
            resp_sel   = sel_q;
            resp_err   = err_q;
        end
        resp_rdata = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            if (resp_sel[i]) begin
                resp_rdata = resp_rdata | (RO_MASK[i] ? i_hw_sts[i*DW +: DW] : reg_q[i]);
            end
        end
        if (resp_write || resp_err) begin
            resp_rdata = '0;
        end
    end

    // Transfer FSM, wait counter, response and write commit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        sel_d      = sel_q;
        err_d      = err_q;
        pready_d   = 1'b0;
        prdata_d   = '0;
        pslverr_d  = 1'b0;
        wr_pulse_d = '0;
        reg_d      = reg_q;

        unique case (state_q)
            StIdle: begin
                if (i_psel && !i_penable) begin
                    write_d = i_pwrite;
                    wdata_d = i_pwdata;
                    strb_d  = i_pstrb;
                    sel_d   = setup_sel;
                    err_d   = setup_err;
                    cnt_d   = i_pwrite ? 4'(WR_WAIT) : 4'(RD_WAIT);
                    state_d = StAccess;
                    if (cnt_d == 4'd0) begin
                        pready_d  = 1'b1;
                        prdata_d  = resp_rdata;
                        pslverr_d = resp_err;
                    end
                end
            end
            StAccess: begin
                if (!i_psel) begin
                    // Abort: drop the transfer without touching any register
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (pready_q) begin
                    state_d = StIdle;
                    if (write_q && !err_q) begin
                        for (int unsigned i = 0; i < N_REG; i++) begin
                            if (sel_q[i] && !RO_MASK[i]) begin
                                for (int unsigned b = 0; b < NB; b++) begin
                                    if (strb_q[b]) begin
                                        reg_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                                    end
                                end
                                wr_pulse_d[i] = |strb_q;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    // Raise pready so that it is high in the cycle the counter reaches zero
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        prdata_d  = resp_rdata;
                        pslverr_d = resp_err;
                    end
                end
            end
        endcase
    end

    // State, capture and output registers with synchronous active-high reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            sel_q      <= '0;
            err_q      <= 1'b0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < N_REG; i++) begin
                reg_q[i] <= RO_MASK[i] ? '0 : RST_VAL;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            sel_q      <= sel_d;
            err_q      <= err_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
            reg_q      <= reg_d;
        end
    end

    assign o_pready   = pready_q;
    assign o_prdata   = prdata_q;
    assign o_pslverr  = pslverr_q;
    assign o_wr_pulse = wr_pulse_q;

    // Flatten the register file; RO entries are never written and stay zero
    always_comb begin
        o_hw_ctl = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            o_hw_ctl[i*DW +: DW] = reg_q[i];
        end
    end

    // Low address bits, unused status slices and pprot[2:1] are intentionally ignored
    logic unused_inputs;
`ifdef APB_REGFILE_PPROT_EN
    assign unused_inputs = ^{i_paddr, i_hw_sts, i_pprot};
`else
    assign unused_inputs = ^{i_paddr, i_hw_sts};
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed APB transfers against a transaction-level model of the
// register file; outputs are compared every cycle, plus literal checks on key results.
module tb_apb_regfile_slave;

    localparam int unsigned NR   = 8;
    localparam int unsigned RD_W = 1;
    localparam int unsigned WR_W = 3;
    localparam logic [7:0]  RO_M = 8'h08;
    localparam logic [7:0]  WO_M = 8'h02;
    localparam logic [7:0]  PRIV_M = 8'h01;

    logic         pclk = 1'b0;
    logic         preset;
    logic [7:0]   i_paddr;
    logic         i_pwrite;
    logic         i_psel;
    logic         i_penable;
    logic [31:0]  i_pwdata;
    logic [3:0]   i_pstrb;
    logic [2:0]   i_pprot;
    logic [31:0]  o_prdata;
    logic         o_pslverr;
    logic         o_pready;
    logic [255:0] o_hw_ctl;
    logic [255:0] hw_sts;
    logic [7:0]   o_wr_pulse;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(
        .DW       (32),
        .AW       (8),
        .N_REG    (NR),
        .RO_MASK  (RO_M),
        .WO_MASK  (WO_M),
        .RD_WAIT  (RD_W),
        .WR_WAIT  (WR_W),
        .RST_VAL  (32'h0)
`ifdef APB_REGFILE_PPROT_EN
        ,
        .PRIV_MASK(PRIV_M)
`endif
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .i_paddr   (i_paddr),
        .i_pwrite  (i_pwrite),
        .i_psel    (i_psel),
        .i_penable (i_penable),
        .i_pwdata  (i_pwdata),
        .i_pstrb   (i_pstrb),
`ifdef APB_REGFILE_PPROT_EN
        .i_pprot   (i_pprot),
`endif
        .o_prdata  (o_prdata),
        .o_pslverr (o_pslverr),
        .o_pready  (o_pready),
        .o_hw_ctl  (o_hw_ctl),
        .i_hw_sts  (hw_sts),
        .o_wr_pulse(o_wr_pulse)
    );

    // Model state
    logic [31:0] model_regs [NR];
    logic        exp_pready, nxt_pready;
    logic [31:0] exp_prdata, nxt_prdata;
    logic        exp_err, nxt_err;
    logic [7:0]  exp_pulse, nxt_pulse;
    logic        pend_we;
    int unsigned pend_idx;
    logic [31:0] pend_data;
    logic [3:0]  pend_strb;
    logic        chk_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          pulse_cnt [NR];

    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [255:0] model_ctl();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = RO_M[i] ? 32'h0 : model_regs[i];
        return v;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge pclk) begin
        if (chk_en) begin
            check("cyc_pready", 256'(o_pready), 256'(exp_pready));
            check("cyc_prdata", 256'(o_prdata), 256'(exp_prdata));
            check("cyc_pslverr", 256'(o_pslverr), 256'(exp_err));
            check("cyc_wr_pulse", 256'(o_wr_pulse), 256'(exp_pulse));
            check("cyc_hw_ctl", o_hw_ctl, model_ctl());
            for (int i = 0; i < NR; i++) pulse_cnt[i] += int'(o_wr_pulse[i]);
        end
    end

    // Advance one clock; apply what the model decided for the edge just taken
    task automatic tick();
        logic rst_s;
        rst_s = preset;
        @(posedge pclk);
        #1;
        if (rst_s) begin
            for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
            exp_pready = 1'b0;
            exp_prdata = 32'h0;
            exp_err    = 1'b0;
            exp_pulse  = 8'h0;
        end else begin
            if (pend_we) begin
                for (int b = 0; b < 4; b++)
                    if (pend_strb[b]) model_regs[pend_idx][b*8 +: 8] = pend_data[b*8 +: 8];
            end
            exp_pready = nxt_pready;
            exp_prdata = nxt_prdata;
            exp_err    = nxt_err;
            exp_pulse  = nxt_pulse;
        end
        nxt_pready = 1'b0;
        nxt_prdata = 32'h0;
        nxt_err    = 1'b0;
        nxt_pulse  = 8'h0;
        pend_we    = 1'b0;
    endtask

    // One APB transfer starting in the current cycle; abort_at>0 drops psel in that access cycle
    task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int abort_at,
                        output logic [31:0] rdata, output logic rerr);
        int unsigned idx;
        int          w;
        logic        err;
        logic        priv_bad;
        idx      = int'(addr[7:2]);
        priv_bad = 1'b0;
`ifdef APB_REGFILE_PPROT_EN
        if (idx < NR) priv_bad = PRIV_M[idx] && !prot[0];
`endif
        if (idx >= NR) err = 1'b1;
        else err = priv_bad || (wr ? RO_M[idx] : WO_M[idx]);
        w = wr ? int'(WR_W) : int'(RD_W);
        i_psel    = 1'b1;
        i_penable = 1'b0;
        i_paddr   = addr;
        i_pwrite  = wr;
        i_pwdata  = wdata;
        i_pstrb   = strb;
        i_pprot   = prot;
        for (int c = 0; c <= w; c++) begin
            if (abort_at > 0 && c == abort_at) begin
                i_psel    = 1'b0;
                i_penable = 1'b0;
                tick();
                rdata = 32'h0;
                rerr  = 1'b0;
                return;
            end
            if (c == w) begin
                nxt_pready = 1'b1;
                nxt_err    = err;
                if (wr || err) nxt_prdata = 32'h0;
                else nxt_prdata = RO_M[idx] ? hw_sts[idx*32 +: 32] : model_regs[idx];
            end
            tick();
            i_penable = 1'b1;
        end
        rdata = o_prdata;
        rerr  = o_pslverr;
        check("xfer_pready", 256'(o_pready), 256'(1'b1));
        if (wr && !err && strb != 4'h0) begin
            pend_we        = 1'b1;
            pend_idx       = idx;
            pend_data      = wdata;
            pend_strb      = strb;
            nxt_pulse[idx] = 1'b1;
        end
        tick();
        i_psel    = 1'b0;
        i_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        preset = 1'b1;
        i_psel = 1'b0; i_penable = 1'b0; i_paddr = 8'h0; i_pwrite = 1'b0;
        i_pwdata = 32'h0; i_pstrb = 4'h0; i_pprot = 3'b001;
        for (int i = 0; i < NR; i++) begin
            hw_sts[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
            model_regs[i] = 32'h0;
            pulse_cnt[i] = 0;
        end
        hw_sts[3*32 +: 32] = 32'hDEAD_BEEF;
        nxt_pready = 1'b0; nxt_prdata = 32'h0; nxt_err = 1'b0; nxt_pulse = 8'h0;
        pend_we = 1'b0; pend_idx = 0; pend_data = 32'h0; pend_strb = 4'h0;
        tick();
        tick();
        preset = 1'b0;
        chk_en = 1'b1;
        check("reset_hw_ctl", o_hw_ctl, 256'h0);
        check("reset_pready", 256'(o_pready), 256'h0);

        // Read reg0 after reset
        xfer(8'h00, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t1_rdata", 256'(rd), 256'h0);
        check("t1_err", 256'(er), 256'h0);

        // Strobed writes to reg2, back-to-back
        xfer(8'h08, 1'b1, 32'hA5A5_A5A5, 4'b1111, 3'b001, 0, rd, er);
        xfer(8'h08, 1'b1, 32'h1234_5678, 4'b0101, 3'b001, 0, rd, er);
        xfer(8'h08, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t2_rdata", 256'(rd), 256'hA534_A578);
        check("t2_err", 256'(er), 256'h0);
        check("t2_model", 256'(model_regs[2]), 256'hA534_A578);
        check("t2_hw_ctl2", 256'(o_hw_ctl[95:64]), 256'hA534_A578);
        check("t2_pulses", 256'(pulse_cnt[2]), 256'd2);

        // RO reg3
        xfer(8'h0C, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t3_ro_rdata", 256'(rd), 256'hDEAD_BEEF);
        check("t3_ro_err", 256'(er), 256'h0);
        xfer(8'h0C, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, rd, er);
        check("t3_ro_wr_err", 256'(er), 256'h1);
        tick();
        check("t3_ro_pulses", 256'(pulse_cnt[3]), 256'd0);
        check("t3_hw_ctl3", 256'(o_hw_ctl[127:96]), 256'h0);

        // WO reg1, unmapped, zero strobe
        xfer(8'h04, 1'b1, 32'h0F0F_0F0F, 4'hF, 3'b001, 0, rd, er);
        check("t4_wo_wr_err", 256'(er), 256'h0);
        xfer(8'h04, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t4_wo_rdata", 256'(rd), 256'h0);
        check("t4_wo_err", 256'(er), 256'h1);
        xfer(8'h40, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t4_unmapped_rdata", 256'(rd), 256'h0);
        check("t4_unmapped_err", 256'(er), 256'h1);
        xfer(8'h10, 1'b1, 32'h7777_7777, 4'h0, 3'b001, 0, rd, er);
        check("t4_nostrb_err", 256'(er), 256'h0);
        tick();
        check("t4_nostrb_pulses", 256'(pulse_cnt[4]), 256'd0);
        check("t4_hw_ctl1", 256'(o_hw_ctl[63:32]), 256'h0F0F_0F0F);

        // penable without a setup phase is ignored
        i_psel = 1'b1; i_penable = 1'b1; i_paddr = 8'h14; i_pwrite = 1'b1; i_pstrb = 4'hF;
        tick();
        tick();
        i_psel = 1'b0; i_penable = 1'b0;
        tick();

        // Low address bits ignored
        xfer(8'h15, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b001, 0, rd, er);
        xfer(8'h17, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t5_lowbits_rdata", 256'(rd), 256'hCAFE_F00D);

        // Abort during write wait states
        xfer(8'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, 2, rd, er);
        tick();
        check("t5_abort_hw_ctl1", 256'(o_hw_ctl[63:32]), 256'h0F0F_0F0F);
        check("t5_abort_pulses", 256'(pulse_cnt[1]), 256'd1);

        // Reset in the middle of a read
        i_psel = 1'b1; i_penable = 1'b0; i_paddr = 8'h08; i_pwrite = 1'b0;
        tick();
        i_penable = 1'b1;
        preset = 1'b1;
        tick();
        preset = 1'b0; i_psel = 1'b0; i_penable = 1'b0;
        check("t5_rst_pready", 256'(o_pready), 256'h0);
        check("t5_rst_hw_ctl", o_hw_ctl, 256'h0);
        tick();
        xfer(8'h08, 1'b0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check("t5_after_rst_rdata", 256'(rd), 256'h0);
        check("t5_after_rst_err", 256'(er), 256'h0);

`ifdef APB_REGFILE_PPROT_EN
        // Privileged register 0
        xfer(8'h00, 1'b1, 32'h5555_5555, 4'hF, 3'b000, 0, rd, er);
        check("t6_unpriv_err", 256'(er), 256'h1);
        check("t6_unpriv_hw_ctl0", 256'(o_hw_ctl[31:0]), 256'h0);
        xfer(8'h00, 1'b1, 32'h5555_5555, 4'hF, 3'b001, 0, rd, er);
        check("t6_priv_err", 256'(er), 256'h0);
        tick();
        check("t6_priv_hw_ctl0", 256'(o_hw_ctl[31:0]), 256'h5555_5555);
        xfer(8'h00, 1'b0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        check("t6_unpriv_rd_rdata", 256'(rd), 256'h0);
        check("t6_unpriv_rd_err", 256'(er), 256'h1);
`endif

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
